// File: rtl/div_pkg.sv
// Shared types and constants for the sequential MIPS divider.
package div_pkg;

  localparam int DIV_WIDTH  = 32;
  localparam int DIV_CYCLES = 32;
  localparam int DIV_CNT_W  = 6;

  typedef enum logic [1:0] {
    IDLE,
    ON,
    DONE
  } div_state_t;

endpackage

// File: rtl/div_datapath.sv
// Radix-2 restoring divider datapath: {R,Q} shift register, trial subtractor,
// sign fix-up and the committed lo/hi result registers.
module div_datapath
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             finish,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  logic [2*WIDTH-1:0] rq_reg;
  logic [WIDTH-1:0]   dvs_reg;
  logic               neg_q_reg;
  logic               neg_r_reg;
  logic [WIDTH-1:0]   lo_reg;
  logic [WIDTH-1:0]   hi_reg;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     partial;
  logic [WIDTH+1:0]   trial;
  logic               fits;
  logic [2*WIDTH-1:0] rq_next;
  logic [WIDTH-1:0]   q_fin;
  logic [WIDTH-1:0]   r_fin;

  assign a_mag = (signed_op && a[WIDTH-1]) ? -a : a;
  assign b_mag = (signed_op && b[WIDTH-1]) ? -b : b;

  // Shifted remainder keeps its carry-out bit so 2R+1 never overflows the compare.
  assign partial = rq_reg[2*WIDTH-1:WIDTH-1];
  assign trial   = {1'b0, partial} - {2'b00, dvs_reg};
  assign fits    = ~trial[WIDTH+1];
  assign rq_next = {(fits ? trial[WIDTH-1:0] : partial[WIDTH-1:0]),
                    rq_reg[WIDTH-2:0], fits};

  // The final step and the sign fix-up land in lo/hi on the same edge.
  assign q_fin = rq_next[WIDTH-1:0];
  assign r_fin = rq_next[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rq_reg    <= '0;
      dvs_reg   <= '0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
      lo_reg    <= '0;
      hi_reg    <= '0;
    end else begin
      if (load) begin
        rq_reg    <= {{WIDTH{1'b0}}, a_mag};
        dvs_reg   <= b_mag;
        neg_q_reg <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_r_reg <= signed_op & a[WIDTH-1];
        if (b == '0) begin
          lo_reg <= '1;
          hi_reg <= a;
        end
      end else if (step) begin
        rq_reg <= rq_next;
      end
      if (finish) begin
        lo_reg <= neg_q_reg ? -q_fin : q_fin;
        hi_reg <= neg_r_reg ? -r_fin : r_fin;
      end
    end
  end

  assign lo = lo_reg;
  assign hi = hi_reg;

endmodule

// File: rtl/div_seq.sv
// Multi-cycle DIV/DIVU unit for the execute stage: sequencing FSM plus
// the pipeline stall and result-valid handshake.
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             startE,
  input  logic             signedE,
  input  logic             annul,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stall_divE,
  output logic             result_valid,
  output logic             busy,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam logic [DIV_CNT_W-1:0] LAST_CNT = DIV_CNT_W'(WIDTH - 1);

  div_state_t           state_reg, state_next;
  logic [DIV_CNT_W-1:0] cnt_reg, cnt_next;
  logic                 load, step, finish;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (startE && !annul) begin
          load       = 1'b1;
          cnt_next   = '0;
          state_next = (b == '0) ? DONE : ON;
        end
      end
      ON: begin
        if (annul) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          step     = 1'b1;
          cnt_next = cnt_reg + DIV_CNT_W'(1);
          if (cnt_reg == LAST_CNT) begin
            finish     = 1'b1;
            cnt_next   = '0;
            state_next = DONE;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Stall drops in DONE so the instruction leaves E on the following edge.
  assign stall_divE   = startE & ~annul & (state_reg != DONE);
  assign result_valid = (state_reg == DONE) & ~annul;
  assign busy         = (state_reg != IDLE);

  div_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (step),
    .finish   (finish),
    .signed_op(signedE),
    .a        (a),
    .b        (b),
    .lo       (lo),
    .hi       (hi)
  );

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: vector table, corner sequences, random vs model.
module tb_div_seq;
  import div_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        startE = 1'b0;
  logic        signedE = 1'b0;
  logic        annul = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        stall_divE, result_valid, busy;
  logic [31:0] lo, hi;

  int n_tests = 0;
  int n_fail  = 0;

  div_seq #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .startE      (startE),
    .signedE     (signedE),
    .annul       (annul),
    .a           (a),
    .b           (b),
    .stall_divE  (stall_divE),
    .result_valid(result_valid),
    .busy        (busy),
    .lo          (lo),
    .hi          (hi)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (!rst) assert (!busy || result_valid || annul || startE)
      else $error("startE dropped while the divider was busy");

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [31:0] lo;
    logic [31:0] hi;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  // Plain-arithmetic reference for MIPS DIV/DIVU with the local div-by-zero rule.
  task automatic ref_div(input logic [31:0] ra, input logic [31:0] rb, input logic sgn,
                         output logic [31:0] rlo, output logic [31:0] rhi);
    int sa, sb;
    if (rb == 0) begin
      rlo = 32'hFFFF_FFFF;
      rhi = ra;
    end else if (!sgn) begin
      rlo = ra / rb;
      rhi = ra % rb;
    end else if (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) begin
      rlo = 32'h8000_0000;
      rhi = 32'h0;
    end else begin
      sa  = $signed(ra);
      sb  = $signed(rb);
      rlo = 32'(sa / sb);
      rhi = 32'(sa % sb);
    end
  endtask

  // Starts a divide at the current (post-negedge) time, counts stall and
  // result_valid cycles through DONE plus one following cycle.
  task automatic do_div(input logic [31:0] ia, input logic [31:0] ib, input logic isgn,
                        input bit keep_start, output int stall_n, output int rv_n,
                        output logic [31:0] rlo, output logic [31:0] rhi);
    bit done = 0;
    startE  = 1'b1;
    a       = ia;
    b       = ib;
    signedE = isgn;
    stall_n = 0;
    rv_n    = 0;
    rlo     = 'x;
    rhi     = 'x;
    for (int c = 0; c < 100 && !done; c++) begin
      #1;
      if (result_valid) begin
        rv_n++;
        rlo = lo;
        rhi = hi;
      end
      if (stall_divE) begin
        stall_n++;
        @(negedge clk);
      end else begin
        done = 1;
      end
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL timeout: stall_divE still 1 after 100 cycles, expected release");
    end
    if (!keep_start) startE = 1'b0;
    @(negedge clk);
    #1;
    if (result_valid) rv_n++;
  endtask

  task automatic run_check(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                           input logic isgn, input bit keep_start, output int stall_n);
    logic [31:0] elo, ehi, glo, ghi;
    int rv_n;
    ref_div(ia, ib, isgn, elo, ehi);
    do_div(ia, ib, isgn, keep_start, stall_n, rv_n, glo, ghi);
    $display("[TB] %s %s a=0x%08h b=0x%08h lo=0x%08h hi=0x%08h stall=%0d rv=%0d",
             tag, isgn ? "DIV " : "DIVU", ia, ib, glo, ghi, stall_n, rv_n);
    check({tag, " lo"}, glo, elo);
    check({tag, " hi"}, ghi, ehi);
    check({tag, " stall"}, 32'(stall_n), (ib == 0) ? 32'd1 : 32'(DIV_CYCLES + 1));
    check({tag, " rv_pulses"}, 32'(rv_n), 32'd1);
  endtask

  initial begin
    int s1, s2, rv_cnt;
    logic [31:0] prev_lo, prev_hi, ra, rb;
    logic rs;

    vecs[0] = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2};
    vecs[1] = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF};
    vecs[2] = '{32'hFFFF_FFF9,  32'd2,          1'b0, 32'h7FFF_FFFC,  32'd1};
    vecs[3] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0};
    vecs[4] = '{32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5};
    vecs[5] = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1};
    vecs[6] = '{32'd0,          32'd5,          1'b1, 32'd0,          32'd0};
    vecs[7] = '{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0};
    vecs[8] = '{32'hFFFF_FFFB,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFB};

    // Asynchronous reset with the clock low: outputs must clear before any edge.
    #1 rst = 1'b1;
    #1;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset result_valid", {31'd0, result_valid}, 32'd0);
    check("reset stall", {31'd0, stall_divE}, 32'd0);
    check("reset lo", lo, 32'd0);
    check("reset hi", hi, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      logic [31:0] glo, ghi;
      int st, rv;
      do_div(vecs[i].a, vecs[i].b, vecs[i].sgn, 1'b0, st, rv, glo, ghi);
      $display("[TB] vec%0d a=0x%08h b=0x%08h sgn=%0d lo=0x%08h hi=0x%08h stall=%0d rv=%0d",
               i, vecs[i].a, vecs[i].b, vecs[i].sgn, glo, ghi, st, rv);
      check($sformatf("vec%0d lo", i), glo, vecs[i].lo);
      check($sformatf("vec%0d hi", i), ghi, vecs[i].hi);
      check($sformatf("vec%0d stall", i), 32'(st),
            (vecs[i].b == 0) ? 32'd1 : 32'd33);
      check($sformatf("vec%0d rv_pulses", i), 32'(rv), 32'd1);
    end

    // Annul at T10 of 100/7.
    prev_lo = lo;
    prev_hi = hi;
    startE = 1'b1; a = 32'd100; b = 32'd7; signedE = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
    end
    annul = 1'b1;
    #1;
    check("annul stall", {31'd0, stall_divE}, 32'd0);
    check("annul busy_T10", {31'd0, busy}, 32'd1);
    @(negedge clk);
    #1;
    annul = 1'b0;
    startE = 1'b0;
    #1;
    check("annul idle_T11", {31'd0, busy}, 32'd0);
    check("annul stall_T11", {31'd0, stall_divE}, 32'd0);
    rv_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      if (result_valid) rv_cnt++;
    end
    $display("[TB] annul 100/7 at T10 lo=0x%08h hi=0x%08h rv=%0d", lo, hi, rv_cnt);
    check("annul rv_pulses", 32'(rv_cnt), 32'd0);
    check("annul lo_kept", lo, prev_lo);
    check("annul hi_kept", hi, prev_hi);

    // Back-to-back DIVU 20/3 then 9/4.
    run_check("b2b_1", 32'd20, 32'd3, 1'b0, 1'b1, s1);
    check("b2b T0 follows DONE", {31'd0, stall_divE}, 32'd1);
    run_check("b2b_2", 32'd9, 32'd4, 1'b0, 1'b0, s2);
    check("b2b total stall", 32'(s1 + s2), 32'd66);

    // Reset at T15, then a fresh 100/7.
    startE = 1'b1; a = 32'd100; b = 32'd7; signedE = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    $display("[TB] rst at T15 busy=%0d lo=0x%08h hi=0x%08h rv=%0d", busy, lo, hi, result_valid);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst lo", lo, 32'd0);
    check("rst hi", hi, 32'd0);
    check("rst result_valid", {31'd0, result_valid}, 32'd0);
    startE = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    run_check("after_rst", 32'd100, 32'd7, 1'b0, 1'b0, s1);

    // Randomized operands against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      int sel;
      sel = $urandom_range(0, 9);
      ra  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case (sel)
        0:       rb = 32'd0;
        1, 2, 3: rb = 32'($urandom_range(1, 20));
        4:       rb = 32'hFFFF_FFFF;
        5:       rb = -32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      rs = 1'($urandom_range(0, 1));
      run_check($sformatf("rand%0d", i), ra, rb, rs, 1'b0, s1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
